bf_recency_stack: RTL and testbench



---
 rtl/bf_pkg.sv | 22 ++
 rtl/bf_match_finder.sv | 25 ++
 rtl/bf_recency_stack.sv | 94 +++++++++
 tb/tb_bf_recency_stack.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared sizing, the array types handed to index_perceptron_BF, and the
// saturating position increment.
package bf_pkg;

   localparam int unsigned DEPTH  = 48;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned POS_W  = 6;
   localparam int unsigned IDX_W  = $clog2(DEPTH + 1);

   localparam logic [POS_W-1:0] POS_MAX = '1;

   typedef logic [ADDR_W:1][DEPTH:1] Branch;
   typedef logic [POS_W:1][DEPTH:1]  Pos;

   typedef logic [DEPTH:1][ADDR_W-1:0] addr_arr_t;
   typedef logic [DEPTH:1][POS_W-1:0]  pos_arr_t;

   function automatic logic [POS_W-1:0] pos_sat_inc(input logic [POS_W-1:0] p);
      return (p == POS_MAX) ? p : p + POS_W'(1);
   endfunction

endpackage

// File: rtl/bf_match_finder.sv
// Combinational search of the valid stack entries for a resolved PC;
// reports the lowest matching entry index.
module bf_match_finder
   import bf_pkg::*;
(
   input  logic [ADDR_W-1:0] pc_i,
   input  addr_arr_t         addr_i,
   input  logic [POS_W-1:0]  count_i,
   output logic              hit_c_o,
   output logic [IDX_W-1:0]  idx_c_o
);

   // Walk from the deepest entry upward so the lowest index is the last writer.
   always_comb begin
      hit_c_o = 1'b0;
      idx_c_o = '0;
      for (int unsigned m = DEPTH; m >= 1; m--) begin
         if ((m <= 32'(count_i)) && (addr_i[m] == pc_i)) begin
            hit_c_o = 1'b1;
            idx_c_o = IDX_W'(m);
         end
      end
   end

endmodule

// File: rtl/bf_recency_stack.sv
// Bias-free predictor recency stack: up to DEPTH unique non-biased branches,
// most recent at entry 1, each with last outcome and global-history position.
module bf_recency_stack
   import bf_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               upd_valid,
   input  logic [ADDR_W-1:0]  upd_pc,
   input  logic               upd_taken,
   input  logic               upd_biased,
   output Branch              Branch_address_iterative,
   output Pos                 Pos_iterative,
   output logic [DEPTH:1]     Folded_hist_iterative,
   output logic [POS_W-1:0]   valid_count
);

   addr_arr_t        addr_q, addr_d;
   pos_arr_t         pos_q, pos_d;
   logic [DEPTH:1]   hist_q, hist_d;
   logic [POS_W-1:0] cnt_q, cnt_d;

   logic             hit;
   logic [IDX_W-1:0] hit_idx;

   bf_match_finder u_match (
      .pc_i    (upd_pc),
      .addr_i  (addr_q),
      .count_i (cnt_q),
      .hit_c_o (hit),
      .idx_c_o (hit_idx)
   );

   always_comb begin
      addr_d = addr_q;
      pos_d  = pos_q;
      hist_d = hist_q;
      cnt_d  = cnt_q;
      if (flush) begin
         addr_d = '0;
         pos_d  = '0;
         hist_d = '0;
         cnt_d  = '0;
      end else if (upd_valid && upd_biased) begin
         for (int unsigned m = 1; m <= DEPTH; m++) begin
            if (m <= 32'(cnt_q)) pos_d[m] = pos_sat_inc(pos_q[m]);
         end
      end else if (upd_valid) begin
         // On a hit only entries above the hit slot shift; on a miss all do.
         for (int unsigned m = 2; m <= DEPTH; m++) begin
            if (!hit || (m <= 32'(hit_idx))) begin
               addr_d[m] = addr_q[m-1];
               hist_d[m] = hist_q[m-1];
               pos_d[m]  = ((m - 1) <= 32'(cnt_q)) ? pos_sat_inc(pos_q[m-1]) : '0;
            end else if (m <= 32'(cnt_q)) begin
               pos_d[m] = pos_sat_inc(pos_q[m]);
            end
         end
         addr_d[1] = upd_pc;
         hist_d[1] = upd_taken;
         pos_d[1]  = POS_W'(1);
         if (!hit && (cnt_q != POS_W'(DEPTH))) cnt_d = cnt_q + POS_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         pos_q  <= '0;
         hist_q <= '0;
         cnt_q  <= '0;
      end else begin
         addr_q <= addr_d;
         pos_q  <= pos_d;
         hist_q <= hist_d;
         cnt_q  <= cnt_d;
      end
   end

   // Re-lay the per-entry registers into the bit-major arrays the consumer expects.
   always_comb begin
      Branch_address_iterative = '0;
      Pos_iterative            = '0;
      for (int unsigned m = 1; m <= DEPTH; m++) begin
         for (int unsigned b = 1; b <= ADDR_W; b++) Branch_address_iterative[b][m] = addr_q[m][b-1];
         for (int unsigned b = 1; b <= POS_W; b++)  Pos_iterative[b][m]            = pos_q[m][b-1];
      end
   end

   assign Folded_hist_iterative = hist_q;
   assign valid_count           = cnt_q;

endmodule

// File: tb/tb_bf_recency_stack.sv
// Scoreboard bench for bf_recency_stack: queue-based recency model, directed
// scenarios followed by random traffic.
module tb_bf_recency_stack;
   import bf_pkg::*;

   logic clk = 1'b0;
   logic rst_n, flush, upd_valid, upd_taken, upd_biased;
   logic [15:0] upd_pc;
   Branch ba;
   Pos po;
   logic [48:1] fh;
   logic [5:0] vc;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   bf_recency_stack dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .upd_valid(upd_valid),
      .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_biased(upd_biased),
      .Branch_address_iterative(ba), .Pos_iterative(po),
      .Folded_hist_iterative(fh), .valid_count(vc)
   );

   typedef struct packed { logic [15:0] a; logic t; logic [5:0] p; } ent_t;
   typedef struct packed {
      logic [48:1][15:0] a;
      logic [48:1][5:0]  p;
      logic [48:1]       h;
      logic [5:0]        c;
   } snap_t;

   ent_t  mq[$];   // front = most recent
   snap_t sq[$];

   function automatic logic [15:0] dut_addr(int m);
      logic [15:0] r;
      for (int b = 1; b <= 16; b++) r[b-1] = ba[b][m];
      return r;
   endfunction

   function automatic logic [5:0] dut_pos(int m);
      logic [5:0] r;
      for (int b = 1; b <= 6; b++) r[b-1] = po[b][m];
      return r;
   endfunction

   function automatic snap_t model_snap();
      snap_t s;
      s = '0;
      for (int i = 0; i < mq.size(); i++) begin
         s.a[i+1] = mq[i].a;
         s.p[i+1] = mq[i].p;
         s.h[i+1] = mq[i].t;
      end
      s.c = 6'(mq.size());
      return s;
   endfunction

   task automatic model_op(input logic v, input logic [15:0] pc, input logic tk,
                           input logic bi, input logic fl);
      int found;
      ent_t e;
      if (fl) begin
         mq.delete();
      end else if (v) begin
         for (int i = 0; i < mq.size(); i++)
            if (mq[i].p != 6'd63) mq[i].p = mq[i].p + 6'd1;
         if (!bi) begin
            found = -1;
            for (int i = 0; i < mq.size(); i++)
               if (found < 0 && mq[i].a == pc) found = i;
            if (found >= 0) mq.delete(found);
            e.a = pc; e.t = tk; e.p = 6'd1;
            mq.push_front(e);
            if (mq.size() > 48) void'(mq.pop_back());
         end
      end
   endtask

   task automatic op(input logic v, input logic [15:0] pc, input logic tk,
                     input logic bi, input logic fl);
      @(negedge clk);
      upd_valid = v; upd_pc = pc; upd_taken = tk; upd_biased = bi; flush = fl;
      model_op(v, pc, tk, bi, fl);
      sq.push_back(model_snap());
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Lands mid-cycle after the pending op's edge, before the next op is driven.
   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: the stack presents new state after every clock edge.
   always @(posedge clk) begin
      snap_t s;
      snap_t d;
      #1;
      if (rst_n && sq.size() > 0) begin
         s = sq.pop_front();
         d = '0;
         for (int m = 1; m <= 48; m++) begin
            d.a[m] = dut_addr(m);
            d.p[m] = dut_pos(m);
         end
         d.h = fh;
         d.c = vc;
         total += 4;
         if (d.c !== s.c) begin
            bad++;
            $display("FAIL count t=%0t: got %0d expected %0d", $time, d.c, s.c);
         end
         if (d.h !== s.h) begin
            bad++;
            $display("FAIL hist t=%0t: got %h expected %h", $time, d.h, s.h);
         end
         if (d.a !== s.a) begin
            bad++;
            for (int m = 1; m <= 48; m++)
               if (d.a[m] !== s.a[m]) begin
                  $display("FAIL addr t=%0t entry %0d: got %h expected %h", $time, m, d.a[m], s.a[m]);
                  break;
               end
         end
         if (d.p !== s.p) begin
            bad++;
            for (int m = 1; m <= 48; m++)
               if (d.p[m] !== s.p[m]) begin
                  $display("FAIL pos t=%0t entry %0d: got %0d expected %0d", $time, m, d.p[m], s.p[m]);
                  break;
               end
         end
      end
   end

   initial begin
      logic [15:0] pcs;
      rst_n = 1'b0; flush = 1'b0; upd_valid = 1'b0; upd_pc = '0;
      upd_taken = 1'b0; upd_biased = 1'b0;
      #23 rst_n = 1'b1;
      op(0, 16'h0000, 0, 0, 0);

      op(1, 16'h0010, 1, 0, 0);
      op(1, 16'h0020, 0, 0, 0);
      op(1, 16'h0030, 1, 0, 0);
      settle();
      chk("miss3_addr1", dut_addr(1), 16'h0030);
      chk("miss3_addr3", dut_addr(3), 16'h0010);
      chk("miss3_hist", fh[3:1], 3'b101);
      chk("miss3_pos3", dut_pos(3), 3);
      chk("miss3_count", vc, 3);

      op(1, 16'h0010, 0, 0, 0);
      settle();
      chk("hit_addr1", dut_addr(1), 16'h0010);
      chk("hit_addr2", dut_addr(2), 16'h0030);
      chk("hit_addr3", dut_addr(3), 16'h0020);
      chk("hit_hist1", fh[1], 0);

      op(1, 16'h0077, 1, 1, 0);
      op(1, 16'h0078, 0, 1, 0);
      settle();
      chk("bias_pos1", dut_pos(1), 3);
      chk("bias_pos3", dut_pos(3), 5);
      chk("bias_pos4", dut_pos(4), 0);
      chk("bias_count", vc, 3);

      for (int i = 0; i < 48; i++) op(1, 16'h0100 + 16'(i), i[0], 0, 0);
      op(1, 16'h0200, 1, 0, 0);
      settle();
      chk("full_count", vc, 48);
      chk("full_addr1", dut_addr(1), 16'h0200);
      chk("full_addr48", dut_addr(48), 16'h0101);

      op(1, 16'h0055, 1, 0, 1);
      settle();
      chk("flush_count", vc, 0);
      chk("flush_addr1", dut_addr(1), 0);
      chk("flush_hist", fh[1], 0);

      op(1, 16'h0000, 1, 0, 0);
      settle();
      chk("zero_pc_count", vc, 1);
      chk("zero_pc_addr1", dut_addr(1), 0);
      chk("zero_pc_pos1", dut_pos(1), 1);

      for (int i = 0; i < 70; i++) op(1, 16'h0abc, 0, 1, 0);
      settle();
      chk("sat_pos1", dut_pos(1), 63);

      op(1, 16'h0040, 1, 0, 0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_count", vc, 0);
      chk("async_addr1", dut_addr(1), 0);
      chk("async_hist", fh[1], 0);
      chk("async_pos1", dut_pos(1), 0);
      rst_n = 1'b1;
      mq.delete();

      for (int i = 0; i < 2500; i++) begin
         pcs = 16'($urandom_range(0, 70)) << 4;
         op($urandom_range(0, 9) < 8, pcs, 1'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
      end
      for (int i = 0; i < 4; i++) op(0, 16'h0000, 0, 0, 0);
      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", sq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
